load_store_unit: RTL and testbench

Multi-cycle data-memory interface for the RV32I core, and the producing end of the write-back path. It takes core load/store requests, drives a valid/ready data bus and stalls the core until the access completes. On loads it extracts, aligns and sign- or zero-extends the returned word into mem_data, which feeds the write-back select (MemToReg = 2'b01).

---
 rtl/load_store_unit.sv | 233 +++++++++++++++++++++++
 tb/tb_load_store_unit.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle RV32I data-memory interface.
// Accepts core load/store requests, runs a valid/ready bus transaction, stalls
// the core until the access completes and produces the aligned/extended load
// value for the write-back path.
// Optional feature macro: MISALIGN_TRAP_EN (misaligned H/W accesses trap
// instead of using the truncated address).
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned ADDR_W         = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic [2:0]        funct3,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    output logic              lsu_stall,
    output logic [31:0]       mem_data,
    output logic              bus_err,
    output logic              misalign,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [31:0]       bus_wdata,
    output logic [3:0]        bus_be,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [31:0]       bus_rdata
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t            state_r;
    logic [31:0]       tmo_cnt_r;
    logic [2:0]        funct3_r;
    logic [1:0]        addr_lo_r;
    logic              we_r;
    logic [3:0]        be_r;
    logic [31:0]       wdata_r;
    logic [ADDR_W-1:0] bus_addr_r;
    logic              bus_req_r;
    logic [31:0]       mem_data_r;
    logic              bus_err_r;
    logic              misalign_r;

    logic              req_any_s;
    logic              illegal_s;
    logic              misalign_s;
    logic [3:0]        be_s;
    logic [31:0]       wdata_s;
    logic              tmo_hit_s;

    // Pick the addressed byte/half out of the returned word and extend it.
    function automatic logic [31:0] load_extract(input logic [2:0]  f3,
                                                 input logic [1:0]  lo,
                                                 input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (lo)
            2'b00:   b = w[7:0];
            2'b01:   b = w[15:8];
            2'b10:   b = w[23:16];
            2'b11:   b = w[31:24];
            default: b = 8'h00;
        endcase
        h = lo[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  load_extract = {{24{b[7]}}, b};
            3'b001:  load_extract = {{16{h[15]}}, h};
            3'b100:  load_extract = {24'h000000, b};
            3'b101:  load_extract = {16'h0000, h};
            default: load_extract = w;
        endcase
    endfunction

    assign req_any_s = MemRead | MemWrite;
    // The request cycle itself stalls; only the DONE cycle lets the core advance.
    assign lsu_stall = req_any_s && (state_r != ST_DONE);

    assign tmo_hit_s = (TIMEOUT_CYCLES != 32'd0) && ((tmo_cnt_r + 32'd1) == TIMEOUT_CYCLES);

    assign mem_data  = mem_data_r;
    assign bus_err   = bus_err_r;
    assign misalign  = misalign_r;
    assign bus_req   = bus_req_r;
    assign bus_we    = we_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = wdata_r;
    assign bus_be    = be_r;

    // Decode legality, lane enables, replicated store data and misalignment.
    always_comb begin
        illegal_s  = 1'b0;
        misalign_s = 1'b0;
        be_s       = 4'b0000;
        wdata_s    = 32'h00000000;
        if (MemRead && MemWrite) begin
            illegal_s = 1'b1;
        end else if (MemRead) begin
            case (funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_s = 1'b0;
                default:                                illegal_s = 1'b1;
            endcase
        end else if (MemWrite) begin
            case (funct3)
                3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
                default:                illegal_s = 1'b1;
            endcase
        end else begin
            illegal_s = 1'b0;
        end
        case (funct3[1:0])
            2'b00: begin
                be_s    = 4'b0001 << addr[1:0];
                wdata_s = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_s    = 4'b0011 << {addr[1], 1'b0};
                wdata_s = {2{store_data[15:0]}};
            end
            2'b10: begin
                be_s    = 4'b1111;
                wdata_s = store_data;
            end
            default: begin
                be_s    = 4'b0000;
                wdata_s = 32'h00000000;
            end
        endcase
`ifdef MISALIGN_TRAP_EN
        case (funct3[1:0])
            2'b01:   misalign_s = addr[0];
            2'b10:   misalign_s = (addr[1:0] != 2'b00);
            default: misalign_s = 1'b0;
        endcase
`else
        misalign_s = 1'b0;
`endif
    end

    // Access sequencer: accept, request, wait for data, report one DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            tmo_cnt_r  <= 32'd0;
            funct3_r   <= 3'b000;
            addr_lo_r  <= 2'b00;
            we_r       <= 1'b0;
            be_r       <= 4'b0000;
            wdata_r    <= 32'h00000000;
            bus_addr_r <= '0;
            bus_req_r  <= 1'b0;
            mem_data_r <= 32'h00000000;
            bus_err_r  <= 1'b0;
            misalign_r <= 1'b0;
        end else begin
            bus_err_r  <= 1'b0;
            misalign_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s && illegal_s) begin
                        state_r    <= ST_DONE;
                        bus_err_r  <= 1'b1;
                        mem_data_r <= 32'h00000000;
                    end else if (req_any_s && misalign_s) begin
                        state_r    <= ST_DONE;
                        misalign_r <= 1'b1;
                    end else if (req_any_s) begin
                        state_r    <= ST_REQ;
                        tmo_cnt_r  <= 32'd0;
                        funct3_r   <= funct3;
                        addr_lo_r  <= addr[1:0];
                        we_r       <= MemWrite;
                        be_r       <= be_s;
                        wdata_r    <= wdata_s;
                        bus_addr_r <= {addr[ADDR_W-1:2], 2'b00};
                        bus_req_r  <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    tmo_cnt_r <= tmo_cnt_r + 32'd1;
                    if (bus_gnt) begin
                        bus_req_r <= 1'b0;
                        if (we_r) begin
                            state_r <= ST_DONE;
                        end else if (bus_rvalid) begin
                            state_r    <= ST_DONE;
                            mem_data_r <= load_extract(funct3_r, addr_lo_r, bus_rdata);
                        end else begin
                            state_r <= ST_WAIT;
                        end
                    end else if (tmo_hit_s) begin
                        bus_req_r  <= 1'b0;
                        state_r    <= ST_DONE;
                        bus_err_r  <= 1'b1;
                        mem_data_r <= 32'h00000000;
                    end else begin
                        state_r <= ST_REQ;
                    end
                end
                ST_WAIT: begin
                    tmo_cnt_r <= tmo_cnt_r + 32'd1;
                    if (bus_rvalid) begin
                        state_r    <= ST_DONE;
                        mem_data_r <= load_extract(funct3_r, addr_lo_r, bus_rdata);
                    end else if (tmo_hit_s) begin
                        state_r    <= ST_DONE;
                        bus_err_r  <= 1'b1;
                        mem_data_r <= 32'h00000000;
                    end else begin
                        state_r <= ST_WAIT;
                    end
                end
                ST_DONE: begin
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    bus_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and randomized checks of load_store_unit
// against a behavioural access model (lane/extend arithmetic, cycle counts).
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk;
    logic        rst_n;
    logic        MemRead;
    logic        MemWrite;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        lsu_stall;
    logic [31:0] mem_data;
    logic        bus_err;
    logic        misalign;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    int          errors;
    int          checks;
    logic [31:0] exp_mem;

    load_store_unit #(.TIMEOUT_CYCLES(T), .ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .lsu_stall(lsu_stall), .mem_data(mem_data), .bus_err(bus_err),
        .misalign(misalign), .bus_req(bus_req), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
        .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic bit model_legal(input logic rd, input logic wr, input logic [2:0] f3);
        if (rd && wr) return 1'b0;
        if (rd) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        return (f3 <= 3'd2);
    endfunction

    function automatic bit model_misaligned(input logic [2:0] f3, input logic [31:0] a);
`ifdef MISALIGN_TRAP_EN
        int sz;
        sz = (f3 % 4 == 0) ? 1 : ((f3 % 4 == 1) ? 2 : 4);
        return (a % sz) != 0;
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int v;
        if (f3 % 4 == 0)      v = 1 << (a % 4);
        else if (f3 % 4 == 1) v = 3 << (2 * ((a / 2) % 2));
        else                  v = 15;
        return 32'(v);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
        if (f3 % 4 == 0)      return (sd % 256) * 32'h01010101;
        else if (f3 % 4 == 1) return (sd % 65536) * 32'h00010001;
        else                  return sd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        logic [31:0] v;
        if (f3 % 4 == 0) begin
            v = (w >> (8 * (a % 4))) & 32'h000000FF;
            if (f3 == 3'd0 && v >= 32'h00000080) v = v - 32'h00000100;
        end else if (f3 % 4 == 1) begin
            v = (w >> (16 * ((a / 2) % 2))) & 32'h0000FFFF;
            if (f3 == 3'd1 && v >= 32'h00008000) v = v - 32'h00010000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    // One complete core access; gd/rd_dly < 0 means the bus never answers.
    task automatic do_access(input string tag, input logic rd, input logic wr,
                             input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] sd, input int gd, input int rd_dly,
                             input logic [31:0] rdata);
        bit legal, mis, err;
        int tot, n;
        @(negedge clk);
        MemRead = rd; MemWrite = wr; funct3 = f3; addr = a; store_data = sd;
        bus_gnt = 1'b0; bus_rvalid = 1'b0;
        #1 check({tag, ".req_stall"}, 32'(lsu_stall), 32'd1);
        legal = model_legal(rd, wr, f3);
        mis   = legal && model_misaligned(f3, a);
        if (!legal || mis) begin
            @(negedge clk);
            check({tag, ".done_stall"}, 32'(lsu_stall), 32'd0);
            check({tag, ".no_req"}, 32'(bus_req), 32'd0);
            check({tag, ".err"}, 32'(bus_err), 32'(!legal));
            check({tag, ".misalign"}, 32'(misalign), 32'(mis));
            if (!legal) exp_mem = 32'h00000000;
            check({tag, ".mem_data"}, mem_data, exp_mem);
        end else begin
            if (gd < 0)          tot = 1000;
            else if (wr)         tot = gd + 1;
            else if (rd_dly < 0) tot = 1000;
            else                 tot = gd + rd_dly + 1;
            err = (tot > T);
            n   = err ? T : tot;
            for (int k = 0; k < n; k++) begin
                @(negedge clk);
                check({tag, ".busy_stall"}, 32'(lsu_stall), 32'd1);
                check({tag, ".bus_req"}, 32'(bus_req), 32'((gd < 0) || (k <= gd)));
                if (k == 0) begin
                    check({tag, ".bus_addr"}, bus_addr, a - (a % 4));
                    check({tag, ".bus_be"}, 32'(bus_be), model_be(f3, a));
                    check({tag, ".bus_we"}, 32'(bus_we), 32'(wr));
                    if (wr) check({tag, ".bus_wdata"}, bus_wdata, model_wdata(f3, sd));
                end
                bus_gnt    = (gd >= 0) && (k == gd);
                bus_rvalid = !wr && (gd >= 0) && (rd_dly >= 0) && (k == gd + rd_dly);
                bus_rdata  = bus_rvalid ? rdata : $urandom;
            end
            @(negedge clk);
            bus_gnt = 1'b0; bus_rvalid = 1'b0;
            if (err)      exp_mem = 32'h00000000;
            else if (rd)  exp_mem = model_load(f3, a, rdata);
            check({tag, ".done_stall"}, 32'(lsu_stall), 32'd0);
            check({tag, ".done_req"}, 32'(bus_req), 32'd0);
            check({tag, ".err"}, 32'(bus_err), 32'(err));
            check({tag, ".misalign"}, 32'(misalign), 32'd0);
            check({tag, ".mem_data"}, mem_data, exp_mem);
        end
        MemRead = 1'b0; MemWrite = 1'b0;
        @(posedge clk);
        #1 check({tag, ".pulse_gone"}, 32'({bus_err, misalign}), 32'd0);
    endtask

    // Directed sequence followed by randomized accesses.
    initial begin
        logic [2:0] f3_tab [5];
        logic [2:0] f3;
        logic       is_wr;
        errors = 0; checks = 0; exp_mem = 32'h00000000;
        clk = 1'b0; rst_n = 1'b0;
        MemRead = 1'b0; MemWrite = 1'b0; funct3 = 3'd0; addr = 32'd0; store_data = 32'd0;
        bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0;
        #12;
        check("rst.mem_data", mem_data, 32'd0);
        check("rst.bus_req", 32'(bus_req), 32'd0);
        check("rst.flags", 32'({bus_err, misalign, bus_we, lsu_stall}), 32'd0);
        check("rst.bus_addr", bus_addr, 32'd0);
        @(negedge clk); rst_n = 1'b1;

        do_access("lw",  1'b1, 1'b0, 3'd2, 32'h00000100, 32'd0, 1, 1, 32'hDEADBEEF);
        do_access("lb",  1'b1, 1'b0, 3'd0, 32'h00000103, 32'd0, 0, 1, 32'h80112233);
        do_access("lbu", 1'b1, 1'b0, 3'd4, 32'h00000103, 32'd0, 1, 0, 32'h80112233);
        do_access("lh",  1'b1, 1'b0, 3'd1, 32'h00000102, 32'd0, 0, 0, 32'h80112233);
        do_access("lhu", 1'b1, 1'b0, 3'd5, 32'h00000100, 32'd0, 0, 1, 32'h80119233);
        do_access("sb",  1'b0, 1'b1, 3'd0, 32'h00000201, 32'h000000A5, 0, 0, 32'd0);
        do_access("sh",  1'b0, 1'b1, 3'd1, 32'h00000202, 32'h1234BEEF, 1, 0, 32'd0);
        do_access("ld_tmo", 1'b1, 1'b0, 3'd2, 32'h00000300, 32'd0, 0, -1, 32'd0);
        do_access("lw2", 1'b1, 1'b0, 3'd2, 32'h00000104, 32'd0, 0, 0, 32'hCAFEF00D);
        do_access("sw_tmo", 1'b0, 1'b1, 3'd2, 32'h00000400, 32'h11111111, -1, 0, 32'd0);
        do_access("lw3", 1'b1, 1'b0, 3'd2, 32'h00000108, 32'd0, 0, 0, 32'h0BADC0DE);
        do_access("ill_rw",  1'b1, 1'b1, 3'd2, 32'h00000100, 32'd0, 0, 0, 32'd0);
        do_access("ld_ok",   1'b1, 1'b0, 3'd2, 32'h00000100, 32'd0, 0, 0, 32'h55AA55AA);
        do_access("ill_ld",  1'b1, 1'b0, 3'd3, 32'h00000100, 32'd0, 0, 0, 32'd0);
        do_access("ill_st",  1'b0, 1'b1, 3'd4, 32'h00000100, 32'd0, 0, 0, 32'd0);
        do_access("lw_mis",  1'b1, 1'b0, 3'd2, 32'h00000102, 32'd0, 0, 0, 32'h76543210);

        // Reset in the middle of WAIT, then a late rvalid that must be ignored.
        @(negedge clk);
        MemRead = 1'b1; funct3 = 3'd2; addr = 32'h00000500;
        @(negedge clk); bus_gnt = 1'b1;
        @(negedge clk); bus_gnt = 1'b0;
        check("wait.stall", 32'(lsu_stall), 32'd1);
        rst_n = 1'b0; MemRead = 1'b0; exp_mem = 32'h00000000;
        #1;
        check("mrst.bus_req", 32'(bus_req), 32'd0);
        check("mrst.mem_data", mem_data, 32'd0);
        check("mrst.stall", 32'(lsu_stall), 32'd0);
        check("mrst.bus_addr", bus_addr, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); bus_rvalid = 1'b1; bus_rdata = 32'h12345678;
        @(negedge clk); bus_rvalid = 1'b0;
        check("late.mem_data", mem_data, 32'd0);
        check("late.flags", 32'({bus_req, bus_err, lsu_stall}), 32'd0);
        do_access("lw_after", 1'b1, 1'b0, 3'd2, 32'h00000100, 32'd0, 0, 1, 32'h0F0F1234);

        f3_tab[0] = 3'd0; f3_tab[1] = 3'd1; f3_tab[2] = 3'd2; f3_tab[3] = 3'd4; f3_tab[4] = 3'd5;
        for (int i = 0; i < 40; i++) begin
            is_wr = $urandom_range(0, 1) == 1;
            f3 = is_wr ? f3_tab[$urandom_range(0, 2)] : f3_tab[$urandom_range(0, 4)];
            do_access("rnd", !is_wr, is_wr, f3, 32'h00001000 + ($urandom % 64),
                      $urandom, $urandom_range(0, 1), $urandom_range(0, 1), $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
